alu_operand_stage: RTL and testbench

Issue stage directly upstream of the ALU. It holds the 32x32 architectural register file and reads rs/rt. It builds the ALU A/B operands from register, immediate or shamt, and registers them with ALUop into a 1-entry valid/ready output stage that feeds the ALU. A per-register pending scoreboard stalls RAW and WAW hazards until write-back retires the producer.

---
 rtl/alu_operand_stage.sv | 147 ++++++++++++++
 tb/tb_alu_operand_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: register file read, operand build and 1-entry output
// register feeding the ALU. A per-register pending scoreboard stalls issue
// on RAW and WAW hazards until write-back retires the producer.
module alu_operand_stage #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int ALUOP_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_WIDTH-1:0]  in_rs,
  input  logic [ADDR_WIDTH-1:0]  in_rt,
  input  logic [15:0]            in_imm,
  input  logic [4:0]             in_shamt,
  input  logic                   in_a_sel,
  input  logic [1:0]             in_b_sel,
  input  logic [ALUOP_WIDTH-1:0] in_alu_op,
  input  logic [ADDR_WIDTH-1:0]  in_rd,
  input  logic                   in_wen,
  input  logic                   wb_wen,
  input  logic [ADDR_WIDTH-1:0]  wb_addr,
  input  logic [DATA_WIDTH-1:0]  wb_data,
  input  logic [3:0]             wb_strb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_A,
  output logic [DATA_WIDTH-1:0]  out_B,
  output logic [ALUOP_WIDTH-1:0] out_alu_op,
  output logic [ADDR_WIDTH-1:0]  out_rd,
  output logic                   out_wen
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0][DATA_WIDTH-1:0] rf_q;
  logic [NREG-1:0]                 pend_q, pend_d, pend_eff, wb_mask;
  logic [DATA_WIDTH-1:0]           wb_merged, rs_val, rt_val, op_a, op_b;
  logic                            hazard, accept;

  logic                   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]  out_a_q, out_b_q;
  logic [ALUOP_WIDTH-1:0] out_op_q;
  logic [ADDR_WIDTH-1:0]  out_rd_q;
  logic                   out_wen_q;

  // Byte-merge of the write-back data onto the current contents of wb_addr;
  // shared by the register write and the same-cycle read bypass.
  always_comb begin
    wb_merged = rf_q[wb_addr];
    for (int b = 0; b < 4; b++)
      if (wb_strb[b]) wb_merged[b*8 +: 8] = wb_data[b*8 +: 8];
  end

  // Source reads: R0 is hardwired zero, a matching write-back is bypassed.
  always_comb begin
    rs_val = rf_q[in_rs];
    rt_val = rf_q[in_rt];
    if (wb_wen && wb_addr == in_rs) rs_val = wb_merged;
    if (wb_wen && wb_addr == in_rt) rt_val = wb_merged;
    if (in_rs == '0) rs_val = '0;
    if (in_rt == '0) rt_val = '0;
  end

  // Operand select: A from rs or shamt, B from rt or extended immediate.
  always_comb begin
    op_a = in_a_sel ? DATA_WIDTH'(in_shamt) : rs_val;
    case (in_b_sel)
      2'd0:    op_b = rt_val;
      2'd1:    op_b = DATA_WIDTH'({{16{in_imm[15]}}, in_imm});
      2'd2:    op_b = DATA_WIDTH'({16'b0, in_imm});
      default: op_b = '0;
    endcase
  end

  // Hazard detection against the scoreboard, with write-back retiring the
  // producer in the same cycle it arrives.
  always_comb begin
    wb_mask  = wb_wen ? (NREG'(1) << wb_addr) : '0;
    pend_eff = pend_q & ~wb_mask;
    hazard   = (!in_a_sel && pend_eff[in_rs]) ||
               ((in_b_sel == 2'd0) && pend_eff[in_rt]) ||
               (in_wen && in_rd != '0 && pend_eff[in_rd]);
    in_ready = (!out_valid_q || out_ready) && !hazard;
    accept   = in_valid && in_ready;
  end

  // Scoreboard next state: write-back clears, accepted writer sets (set wins).
  always_comb begin
    pend_d = pend_q & ~wb_mask;
    if (accept && in_wen && in_rd != '0) pend_d[in_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Output stage valid: load on accept, drop when consumed without refill.
  always_comb begin
    out_valid_d = out_valid_q;
    if (accept)         out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  // Register file write with byte enables; R0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_q <= '0;
    end else if (wb_wen && wb_addr != '0) begin
      rf_q[wb_addr] <= wb_merged;
    end
  end

  // Scoreboard and output valid flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Output payload loads only on accept, so it holds under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_a_q   <= '0;
      out_b_q   <= '0;
      out_op_q  <= '0;
      out_rd_q  <= '0;
      out_wen_q <= 1'b0;
    end else if (accept) begin
      out_a_q   <= op_a;
      out_b_q   <= op_b;
      out_op_q  <= in_alu_op;
      out_rd_q  <= in_rd;
      out_wen_q <= in_wen;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_A      = out_a_q;
  assign out_B      = out_b_q;
  assign out_alu_op = out_op_q;
  assign out_rd     = out_rd_q;
  assign out_wen    = out_wen_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed testbench for alu_operand_stage.
module tb_alu_operand_stage;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm, in_alu_op;
  logic        in_a_sel, in_wen;
  logic [1:0]  in_b_sel;
  logic        wb_wen;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [3:0]  wb_strb;
  logic        out_valid, out_ready, out_wen;
  logic [31:0] out_A, out_B;
  logic [15:0] out_alu_op;
  logic [4:0]  out_rd;

  int checks = 0;
  int errors = 0;

  alu_operand_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ALUOP_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm), .in_shamt(in_shamt),
    .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_alu_op(in_alu_op),
    .in_rd(in_rd), .in_wen(in_wen),
    .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data), .wb_strb(wb_strb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_A(out_A), .out_B(out_B), .out_alu_op(out_alu_op),
    .out_rd(out_rd), .out_wen(out_wen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; in_rs = 0; in_rt = 0; in_imm = 0; in_shamt = 0;
    in_a_sel = 0; in_b_sel = 0; in_alu_op = 0; in_rd = 0; in_wen = 0;
    wb_wen = 0; wb_addr = 0; wb_data = 0; wb_strb = 0;
    out_ready = 1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt,
                       input logic a, input logic [1:0] b,
                       input logic [15:0] imm, input logic [4:0] sh,
                       input logic [15:0] op, input logic [4:0] rd,
                       input logic wen);
    in_valid = 1; in_rs = rs; in_rt = rt; in_a_sel = a; in_b_sel = b;
    in_imm = imm; in_shamt = sh; in_alu_op = op; in_rd = rd; in_wen = wen;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data,
                    input logic [3:0] strb);
    wb_wen = 1; wb_addr = addr; wb_data = data; wb_strb = strb;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    #1;
    checks++;
    if ({out_valid, out_wen, out_rd, out_alu_op, out_A, out_B} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b A=%h B=%h op=%h rd=%0d wen=%b, expected all zero",
               out_valid, out_A, out_B, out_alu_op, out_rd, out_wen);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    tick(); tick();
    rst = 0;
    tick();
  endtask

  task automatic test_basic();
    idle(); wb(5, 32'h12345678, 4'hF); tick();
    idle(); issue(5, 0, 0, 0, 16'h0, 5'd0, 16'h0001, 0, 0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_ready: got %b expected 1", in_ready);
    end
    tick(); idle();
    checks++;
    if (out_valid !== 1'b1 || out_A !== 32'h12345678 || out_B !== 32'h0 || out_alu_op !== 16'h0001) begin
      errors++;
      $display("FAIL basic_read: got v=%b A=%h B=%h op=%h expected v=1 A=12345678 B=00000000 op=0001",
               out_valid, out_A, out_B, out_alu_op);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_raw_waw();
    idle(); issue(0, 0, 0, 0, 16'h0, 5'd0, 16'h0001, 3, 1); tick();
    checks++;
    if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_wen !== 1'b1) begin
      errors++; $display("FAIL raw_producer: got v=%b rd=%0d wen=%b expected v=1 rd=3 wen=1",
                         out_valid, out_rd, out_wen);
    end
    idle(); issue(3, 0, 0, 0, 16'h0, 5'd0, 16'h0002, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL raw_stall cycle %0d: got in_ready=%b expected 0", i, in_ready);
      end
      tick();
    end
    wb(3, 32'h7, 4'hF);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL raw_release: got in_ready=%b expected 1", in_ready);
    end
    tick(); idle();
    checks++;
    if (out_valid !== 1'b1 || out_A !== 32'h7 || out_alu_op !== 16'h0002) begin
      errors++; $display("FAIL raw_bypass: got v=%b A=%h op=%h expected v=1 A=00000007 op=0002",
                         out_valid, out_A, out_alu_op);
    end
    tick();
    // WAW: a second writer of r6 waits for the first to retire
    issue(0, 0, 1, 1, 16'h0, 5'd0, 16'h0004, 6, 1); tick();
    idle(); issue(0, 0, 1, 1, 16'h0, 5'd0, 16'h0008, 6, 1);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL waw_stall: got in_ready=%b expected 0", in_ready);
    end
    tick();
    wb(6, 32'h55, 4'hF);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL waw_release: got in_ready=%b expected 1", in_ready);
    end
    tick(); idle();
    // the second writer's set won over the same-cycle clear
    issue(6, 0, 0, 1, 16'h0, 5'd0, 16'h0001, 0, 0);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL set_wins: got in_ready=%b expected 0", in_ready);
    end
    wb(6, 32'h66, 4'hF);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL set_wins_release: got in_ready=%b expected 1", in_ready);
    end
    tick(); idle();
    checks++;
    if (out_A !== 32'h66) begin
      errors++; $display("FAIL waw_bypass: got A=%h expected 00000066", out_A);
    end
    tick();
  endtask

  task automatic test_strobe();
    idle(); wb(4, 32'hAABBCCDD, 4'hF); tick();
    idle(); wb(4, 32'h00000011, 4'h1); issue(4, 0, 0, 3, 16'h1234, 5'd0, 16'h0001, 0, 0);
    tick(); idle();
    checks++;
    if (out_A !== 32'hAABBCC11 || out_B !== 32'h0) begin
      errors++; $display("FAIL strobe_bypass: got A=%h B=%h expected A=aabbcc11 B=00000000", out_A, out_B);
    end
    // strb=0 writes nothing but still retires the pending producer
    issue(0, 0, 1, 1, 16'h0, 5'd0, 16'h0001, 4, 1); tick();
    idle(); wb(4, 32'hFFFFFFFF, 4'h0); tick();
    idle(); issue(4, 4, 0, 0, 16'h0, 5'd0, 16'h0001, 0, 0);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL strb0_clears: got in_ready=%b expected 1", in_ready);
    end
    tick(); idle();
    checks++;
    if (out_A !== 32'hAABBCC11 || out_B !== 32'hAABBCC11) begin
      errors++; $display("FAIL strobe_read: got A=%h B=%h expected aabbcc11 both", out_A, out_B);
    end
    // R0 ignores writes, even with a same-cycle read
    wb(0, 32'hDEADBEEF, 4'hF); issue(0, 0, 0, 0, 16'h0, 5'd0, 16'h0001, 0, 1);
    tick(); idle();
    checks++;
    if (out_A !== 32'h0 || out_B !== 32'h0) begin
      errors++; $display("FAIL r0_zero: got A=%h B=%h expected 00000000 both", out_A, out_B);
    end
    issue(0, 0, 0, 0, 16'h0, 5'd0, 16'h0001, 0, 1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL r0_never_pending: got in_ready=%b expected 1", in_ready);
    end
    tick(); idle(); tick();
  endtask

  task automatic test_imm();
    idle();
    issue(0, 0, 1, 1, 16'h8000, 5'd31, 16'h0001, 0, 0); tick();
    checks++;
    if (out_A !== 32'h0000001F || out_B !== 32'hFFFF8000) begin
      errors++; $display("FAIL imm_sext: got A=%h B=%h expected A=0000001f B=ffff8000", out_A, out_B);
    end
    issue(0, 0, 1, 2, 16'h8000, 5'd0, 16'h0001, 0, 0); tick();
    checks++;
    if (out_valid !== 1'b1 || out_A !== 32'h0 || out_B !== 32'h00008000) begin
      errors++; $display("FAIL imm_zext: got v=%b A=%h B=%h expected v=1 A=00000000 B=00008000",
                         out_valid, out_A, out_B);
    end
    issue(0, 0, 1, 1, 16'h7FFF, 5'd1, 16'h0001, 0, 0); tick();
    checks++;
    if (out_valid !== 1'b1 || out_A !== 32'h1 || out_B !== 32'h00007FFF) begin
      errors++; $display("FAIL imm_pos: got v=%b A=%h B=%h expected v=1 A=00000001 B=00007fff",
                         out_valid, out_A, out_B);
    end
    idle(); tick();
  endtask

  task automatic test_back_to_back();
    idle(); out_ready = 0;
    issue(0, 0, 1, 2, 16'h0001, 5'd5, 16'h0010, 7, 0); tick();
    checks++;
    if (out_valid !== 1'b1 || out_A !== 32'h5) begin
      errors++; $display("FAIL bp_first: got v=%b A=%h expected v=1 A=00000005", out_valid, out_A);
    end
    issue(0, 0, 1, 2, 16'h0002, 5'd9, 16'h0020, 8, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_ready cycle %0d: got %b expected 0", i, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_A !== 32'h5 || out_B !== 32'h1 || out_alu_op !== 16'h0010 || out_rd !== 5'd7) begin
        errors++; $display("FAIL bp_hold cycle %0d: got v=%b A=%h B=%h op=%h rd=%0d expected v=1 A=5 B=1 op=0010 rd=7",
                           i, out_valid, out_A, out_B, out_alu_op, out_rd);
      end
    end
    out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got in_ready=%b expected 1", in_ready);
    end
    tick(); idle();
    checks++;
    if (out_valid !== 1'b1 || out_A !== 32'h9 || out_B !== 32'h2 || out_alu_op !== 16'h0020) begin
      errors++; $display("FAIL bp_next: got v=%b A=%h B=%h op=%h expected v=1 A=9 B=2 op=0020",
                         out_valid, out_A, out_B, out_alu_op);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_mid();
    idle(); out_ready = 0;
    issue(0, 0, 1, 1, 16'h0, 5'd0, 16'h0001, 3, 1); tick();
    idle(); out_ready = 0;
    issue(3, 0, 0, 1, 16'h0, 5'd0, 16'h0002, 0, 0);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_stall: got in_ready=%b out_valid=%b expected 0 and 1", in_ready, out_valid);
    end
    rst = 1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_rd !== 5'd0 || out_wen !== 1'b0) begin
      errors++; $display("FAIL mid_reset: got v=%b rd=%0d wen=%b expected all 0", out_valid, out_rd, out_wen);
    end
    tick();
    rst = 0; out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_pending_cleared: got in_ready=%b expected 1", in_ready);
    end
    tick(); idle();
    issue(5, 3, 0, 0, 16'h0, 5'd0, 16'h0001, 0, 0); tick(); idle();
    checks++;
    if (out_valid !== 1'b1 || out_A !== 32'h0 || out_B !== 32'h0) begin
      errors++; $display("FAIL mid_rf_cleared: got v=%b A=%h B=%h expected v=1 A=0 B=0", out_valid, out_A, out_B);
    end
    tick();
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_basic();
    test_raw_waw();
    test_strobe();
    test_imm();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
